// File: rtl/fabric_cfg_pkg.sv
// Shared constants, FSM state type and frame layout for the fabric tile configuration loader.
package fabric_cfg_pkg;

    localparam int CFG_W   = 108;
    localparam int MEM_W   = 4;
    localparam int FRAME_W = CFG_W + MEM_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // The frame arrives LSB first, so the LUT memory lands in the top bits of the shadow.
    typedef struct packed {
        logic [MEM_W-1:0] mem;
        logic [CFG_W-1:0] cfg;
    } frame_t;

endpackage

// File: rtl/cfg_shift_reg.sv
// Shadow register for an incoming configuration frame: LSB-first shifter, bit counter and running parity.
module cfg_shift_reg
    import fabric_cfg_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    output logic [FRAME_W-1:0] shadow,
    output logic               last_bit,
    output logic               parity
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else if (clear) begin
            shadow <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else if (shift_en) begin
            // A bit beyond the frame (the parity bit) only feeds the parity accumulator.
            if (cnt < CNT_W'(FRAME_W)) begin
                shadow <= {bit_in, shadow[FRAME_W-1:1]};
                cnt    <= cnt + 1'b1;
            end
            parity <= parity ^ bit_in;
        end
    end

    assign last_bit = (cnt == CNT_W'(FRAME_W - 1));

endmodule

// File: rtl/fabric_cfg_loader.sv
// Serial configuration loader for one fabric tile; commits a complete frame atomically.
// Optional frame parity check is built when CFG_PARITY_EN is defined.
module fabric_cfg_loader
    import fabric_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [CFG_W-1:0] cfg_out,
    output logic [MEM_W-1:0] mem_out,
    output logic             fabric_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t             state;
    logic               have_cfg;
    logic               xfer;
    logic               clear;
    logic [FRAME_W-1:0] shadow;
    frame_t             shadow_f;
    logic               last_bit;
    logic               parity;

    // Abort outranks a coincident bit, so that bit is never consumed.
    assign xfer     = bit_valid && bit_ready && !abort;
    assign clear    = (state == IDLE) && start;
    assign shadow_f = frame_t'(shadow);

    cfg_shift_reg u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .shift_en (xfer),
        .bit_in   (bit_in),
        .shadow   (shadow),
        .last_bit (last_bit),
        .parity   (parity)
    );

`ifdef CFG_PARITY_EN
    logic err_q;
    assign err = err_q;
`else
    logic unused_parity;
    assign unused_parity = parity;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_out   <= '0;
            mem_out   <= '0;
            fabric_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_ready <= 1'b0;
            have_cfg  <= 1'b0;
`ifdef CFG_PARITY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        fabric_en <= 1'b0;
                        bit_ready <= 1'b1;
`ifdef CFG_PARITY_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        bit_ready <= 1'b0;
                        fabric_en <= have_cfg;
                    end else if (xfer && last_bit) begin
`ifdef CFG_PARITY_EN
                        state     <= CHECK;
`else
                        state     <= COMMIT;
                        bit_ready <= 1'b0;
`endif
                    end
                end
`ifdef CFG_PARITY_EN
                CHECK: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        bit_ready <= 1'b0;
                        fabric_en <= have_cfg;
                    end else if (xfer) begin
                        bit_ready <= 1'b0;
                        // Even parity: frame bits plus parity bit must XOR to zero.
                        if ((parity ^ bit_in) == 1'b0) begin
                            state <= COMMIT;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            err_q     <= 1'b1;
                            fabric_en <= have_cfg;
                        end
                    end
                end
`endif
                COMMIT: begin
                    state     <= IDLE;
                    cfg_out   <= shadow_f.cfg;
                    mem_out   <= shadow_f.mem;
                    done      <= 1'b1;
                    fabric_en <= 1'b1;
                    have_cfg  <= 1'b1;
                    busy      <= 1'b0;
                    bit_ready <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    bit_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
